// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - parameterised up/down counter with prescaler tick, modulo, wrap/saturate, load and LED output
//
// Purpose: divides the board clock down to a one-cycle count enable (tick)
// and steps a modulo-MODULO counter on it, either up or down.
// In sat mode the count stops at the end of its range; otherwise it wraps.
//
// Ports:
//   CLK       in   board clock, rising edge
//   reset     in   asynchronous active-low reset
//   clr       in   synchronous clear (highest priority)
//   pause     in   freeze prescaler and counter
//   up_dn     in   1 = count up, 0 = count down
//   sat       in   1 = saturate at range end, 0 = wrap
//   load      in   synchronous parallel load strobe
//   load_val  in   value to load (clamped to MAX)
//   count     out  registered count value
//   LED       out  count, inverted when OUT_INV = 1
//   tick      out  registered prescaler enable pulse
//   tc        out  registered terminal-count pulse

module param_updown_counter #(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULO  = 16,
  parameter int              DIV     = 100000,
  parameter bit              OUT_INV = 1'b1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             clr,
  input  logic             pause,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] LED,
  output logic             tick,
  output logic             tc
);

  // A one-bit prescaler is kept for DIV = 1 so that the register always exists.
  localparam int              PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
  // MODULO may equal 2**WIDTH, so only MODULO-1 is guaranteed to fit in WIDTH bits.
  localparam logic [WIDTH-1:0] MAX     = WIDTH'(MODULO - 1);

  logic [PW-1:0]    r_pre;
  logic [WIDTH-1:0] r_count;
  logic             r_tick;
  logic             r_tc;

  logic [WIDTH-1:0] w_step_val;
  logic [WIDTH-1:0] w_load_val;
  logic             w_at_term;

  // The terminal value depends on the direction sampled on the step edge.
  assign w_at_term  = up_dn ? (r_count == MAX) : (r_count == '0);
  assign w_load_val = (load_val > MAX) ? MAX : load_val;

  // The increment is only taken below MAX, so it cannot overflow WIDTH bits.
  always_comb begin
    w_step_val = r_count;
    if (up_dn) begin
      if (r_count < MAX) begin
        w_step_val = r_count + WIDTH'(1);
      end else if (!sat) begin
        w_step_val = '0;
      end
    end else begin
      if (r_count != '0) begin
        w_step_val = r_count - WIDTH'(1);
      end else if (!sat) begin
        w_step_val = MAX;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_pre   <= '0;
      r_count <= '0;
      r_tick  <= 1'b0;
      r_tc    <= 1'b0;
    end else if (clr) begin
      r_pre   <= '0;
      r_count <= '0;
      r_tick  <= 1'b0;
      r_tc    <= 1'b0;
    end else if (load) begin
      r_pre   <= '0;
      r_count <= w_load_val;
      r_tick  <= 1'b0;
      r_tc    <= 1'b0;
    end else if (pause) begin
      // A tick pending at this edge is dropped: no step is taken while paused.
      r_tick <= 1'b0;
      r_tc   <= 1'b0;
    end else begin
      if (r_pre == PRE_LAST) begin
        r_pre  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_pre  <= r_pre + PW'(1);
        r_tick <= 1'b0;
      end
      // The step is taken on the edge after the registered tick is high.
      if (r_tick) begin
        r_count <= w_step_val;
        r_tc    <= w_at_term;
      end else begin
        r_tc <= 1'b0;
      end
    end
  end

  assign count = r_count;
  assign tick  = r_tick;
  assign tc    = r_tc;
  assign LED   = OUT_INV ? ~r_count : r_count;

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised successor to the team's 4-bit LED up-counter with reset/pause.
- Replaces the derived slow clock with an internal prescaler that produces a one-cycle clock-enable tick; all logic runs on the single board clock.
- Adds up/down counting, programmable modulo, wrap or saturate mode, parallel load, synchronous clear and a terminal-count pulse.
- Sits between board buttons/switches and the LED bank; width and output polarity are generic.

Parameters:
- WIDTH, 4, counter and LED width in bits (1..32).
- MODULO, 16, count range 0..MODULO-1; legal 2 <= MODULO <= 2**WIDTH. MAX = MODULO-1.
- DIV, 100000, board-clock cycles per count tick; legal DIV >= 1. Prescaler width is max(1, clog2(DIV)).
- OUT_INV, 1, 1 = LED output is bitwise inverted (active-low LEDs), 0 = true polarity.

Ports:
- CLK  in  1  board clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- clr  in  1  synchronous clear, active-high.
- pause  in  1  1 = freeze prescaler and counter.
- up_dn  in  1  1 = count up, 0 = count down.
- sat  in  1  1 = saturate at the end of range, 0 = wrap.
- load  in  1  synchronous parallel load strobe.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  registered count value.
- LED  out  WIDTH  count, inverted when OUT_INV=1 (combinational from count).
- tick  out  1  prescaler enable pulse, registered.
- tc  out  1  terminal-count pulse, registered.

Behaviour:
- Reset (reset=0, asynchronous): count=0, prescaler=0, tick=0, tc=0. LED = all ones when OUT_INV=1, else 0. Release is sampled on the next CLK edge.
- Per-edge priority: clr > load > pause > normal operation.
- clr=1: count=0, prescaler=0, tick=0, tc=0.
- load=1: prescaler=0, tick=0, tc=0. count = load_val if load_val <= MAX, otherwise MAX (clamped). Load applies even while pause=1.
- pause=1: count, prescaler, tick and tc hold their values, except that tick and tc are forced to 0.
- Prescaler (normal operation): increments each cycle.
  - When prescaler == DIV-1: prescaler returns to 0 and tick=1 for exactly one cycle.
  - Otherwise tick=0.
  - DIV=1: tick=1 on every unpaused cycle.
- Step: evaluated on the edge after tick is high (tick registered), with pause=0 and no clr/load. Uses up_dn and sat as sampled on that edge.
  - Up, count < MAX: count+1.
  - Up, count == MAX: 0 if sat=0; hold MAX if sat=1.
  - Down, count > 0: count-1.
  - Down, count == 0: MAX if sat=0; hold 0 if sat=1.
- tc: 1 for exactly one cycle, on the same edge as a step taken while count was at the terminal value (MAX for up, 0 for down), in both wrap and saturate modes. Otherwise 0.
- Changes to up_dn or sat between ticks have no effect until the next step.
- Arithmetic is on WIDTH bits. count never leaves 0..MAX, including when MODULO = 2**WIDTH.
- If load and clr are asserted together, clr wins: count=0.
- Reset asserted mid-tick aborts immediately; the prescaler phase is lost.

Test Plan:
- WIDTH=4, MODULO=10, DIV=4, OUT_INV=1 unless noted.
- Reset then free-run up, sat=0: tick every 4th cycle; count runs 0,1,…,9,0. tc pulses on the 9→0 step. LED shows 0xF,0xE,…,0x6,0xF.
- Down with sat=1 from load_val=2: count 2,1,0,0,0. tc pulses on each step attempted at 0.
- load_val=13 (>MAX): count=9 on the next edge, prescaler restarts. Next tick occurs 4 cycles later.
- pause=1 for 10 cycles at count=5 with prescaler=2: count and prescaler frozen, tick=0. After release, the first tick comes 2 cycles later.
- clr and load asserted in the same cycle with count=7: count=0, tc=0. Then assert reset low mid-prescale: all outputs go to reset values before the next CLK edge.
- DIV=1, OUT_INV=0, MODULO=16: count increments every unpaused cycle, wrapping 15→0 with tc=1. LED equals count.
